mod_type_classifier: RTL and testbench

- Upstream control stage for the demodulated-output selector.
- Watches the AM, FM and PM demodulator streams over fixed sample windows and classifies the modulation as CW, AM, FM, ASK, FSK or PSK.
- Generates the meas/cal/out trigger pulses and the 3-bit signal_type code consumed by the DAC selector, AGC and DC isolator.

---
 rtl/mod_type_classifier_pkg.sv | 39 +++
 rtl/mod_type_classifier_span_tracker.sv | 64 ++++++
 rtl/mod_type_classifier.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_mod_type_classifier.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_type_classifier_pkg.sv
// ---------------------------------------------------------------------------
// mod_type_classifier_pkg
//   Shared definitions for the modulation-type classifier and its consumers
//   (DAC selector, AGC, DC isolator).
//   - TYPE_* : 3-bit signal_type codes.
//   - state_t : classifier FSM state encoding.
//   - chan_sel_t : which demod channel feeds the shape (mid-band) window.
//   - span_width() : width of an unsigned max-min span for a given sample
//     width. One extra bit means the span of two signed samples cannot wrap.
// ---------------------------------------------------------------------------
package mod_type_classifier_pkg;

  localparam logic [2:0] TYPE_CW  = 3'b000;
  localparam logic [2:0] TYPE_AM  = 3'b001;
  localparam logic [2:0] TYPE_FM  = 3'b010;
  localparam logic [2:0] TYPE_NA  = 3'b100;
  localparam logic [2:0] TYPE_ASK = 3'b101;
  localparam logic [2:0] TYPE_FSK = 3'b110;
  localparam logic [2:0] TYPE_PSK = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPAN   = 3'd1,
    ST_SHAPE  = 3'd2,
    ST_DECIDE = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CH_NONE = 2'd0,
    CH_AM   = 2'd1,
    CH_FM   = 2'd2
  } chan_sel_t;

  function automatic int span_width(input int io_width);
    return io_width + 1;
  endfunction

endpackage

// File: rtl/mod_type_classifier_span_tracker.sv
// ---------------------------------------------------------------------------
// mod_type_classifier_span_tracker
//   Running max/min tracker for one signed demodulator channel.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     clear_i      : window start; forgets the previous extremes
//     en_i         : sample strobe (only asserted while the span window runs)
//     sample_i     : signed sample
//     max_o, min_o : running extremes since the last clear
//     span_o       : max_o - min_o as an unsigned value one bit wider
// ---------------------------------------------------------------------------
module mod_type_classifier_span_tracker
  import mod_type_classifier_pkg::*;
#(
  parameter int IO_width = 14
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear_i,
  input  logic                                 en_i,
  input  logic signed [IO_width-1:0]           sample_i,
  output logic signed [IO_width-1:0]           max_o,
  output logic signed [IO_width-1:0]           min_o,
  output logic        [span_width(IO_width)-1:0] span_o
);

  localparam int SPAN_W = span_width(IO_width);

  logic signed [IO_width-1:0] max_q;
  logic signed [IO_width-1:0] min_q;
  // Set until the first enabled sample of a window, which loads both
  // extremes directly instead of comparing against stale values.
  logic                       empty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q   <= '0;
      min_q   <= '0;
      empty_q <= 1'b1;
    end else if (clear_i) begin
      max_q   <= '0;
      min_q   <= '0;
      empty_q <= 1'b1;
    end else if (en_i) begin
      if (empty_q || (sample_i > max_q)) begin
        max_q <= sample_i;
      end
      if (empty_q || (sample_i < min_q)) begin
        min_q <= sample_i;
      end
      empty_q <= 1'b0;
    end
  end

  assign max_o = max_q;
  assign min_o = min_q;

  // Sign-extend both operands so the difference is exact; max >= min always
  // holds, so the result is a non-negative magnitude.
  logic [SPAN_W-1:0] span_d;
  assign span_d = {max_q[IO_width-1], max_q} - {min_q[IO_width-1], min_q};
  assign span_o = span_d;

endmodule

// File: rtl/mod_type_classifier.sv
// ---------------------------------------------------------------------------
// mod_type_classifier
//   Watches the AM/FM/PM demodulator streams over fixed sample windows and
//   classifies the modulation as CW, AM, FM, ASK, FSK or PSK.
//   Sequence: SPAN window (max/min of each channel) -> SHAPE window (count
//   samples of the active channel near its mid level) -> DECIDE -> HOLD.
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     sample_en         : demod sample-valid strobe; windows advance on it
//     start             : one-cycle re-measure request (ignored while busy)
//     auto_en           : restart measurement automatically from IDLE/HOLD
//     AM/FM/PM_demod    : signed demodulator outputs
//     meas_trigger      : pulse as the span window starts
//     cal_trigger       : pulse as the span window ends
//     out_trigger       : pulse on the edge signal_type is updated
//     signal_type       : decided type code (TYPE_* in the package)
//     busy              : high in SPAN, SHAPE and DECIDE
// ---------------------------------------------------------------------------
module mod_type_classifier
  import mod_type_classifier_pkg::*;
#(
  parameter int IO_width  = 14,
  parameter int WIN_LEN   = 65536,
  parameter int HOLD_LEN  = 50_000_000,
  parameter int AM_TH     = 800,
  parameter int FM_TH     = 800,
  parameter int PM_TH     = 800,
  parameter int MID_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_en,
  input  logic                       start,
  input  logic                       auto_en,
  input  logic signed [IO_width-1:0] AM_demod,
  input  logic signed [IO_width-1:0] FM_demod,
  input  logic signed [IO_width-1:0] PM_demod,
  output logic                       meas_trigger,
  output logic                       cal_trigger,
  output logic                       out_trigger,
  output logic [2:0]                 signal_type,
  output logic                       busy
);

  localparam int SPAN_W = span_width(IO_width);
  localparam int WIN_W  = $clog2(WIN_LEN);
  localparam int HOLD_W = $clog2(HOLD_LEN + 1);

  localparam logic [SPAN_W-1:0] AM_TH_V   = SPAN_W'(AM_TH);
  localparam logic [SPAN_W-1:0] FM_TH_V   = SPAN_W'(FM_TH);
  localparam logic [SPAN_W-1:0] PM_TH_V   = SPAN_W'(PM_TH);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
  localparam logic [WIN_W:0]    MID_LIM   = (WIN_W + 1)'(WIN_LEN >> MID_SHIFT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LEN - 1);

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_t                     state_q;
  chan_sel_t                  sel_q;
  logic [WIN_W-1:0]           win_cnt_q;
  logic [WIN_W:0]             mid_cnt_q;
  logic [HOLD_W-1:0]          hold_cnt_q;
  // Low for the first SHAPE cycle, when center/band/channel are latched.
  logic                       shape_armed_q;
  logic signed [IO_width-1:0] center_q;
  logic [SPAN_W-1:0]          band_q;
  logic [2:0]                 signal_type_q;
  logic                       meas_q;
  logic                       cal_q;
  logic                       out_q;
  logic                       busy_q;

  // -------------------------------------------------------------------------
  // Per-channel span trackers (index 0 = AM, 1 = FM, 2 = PM)
  // -------------------------------------------------------------------------
  logic signed [IO_width-1:0] demod   [3];
  logic signed [IO_width-1:0] ch_max  [3];
  logic signed [IO_width-1:0] ch_min  [3];
  logic [SPAN_W-1:0]          ch_span [3];

  logic start_span;
  logic span_en;

  assign demod[0] = AM_demod;
  assign demod[1] = FM_demod;
  assign demod[2] = PM_demod;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_trk
      mod_type_classifier_span_tracker #(
        .IO_width (IO_width)
      ) u_trk (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (start_span),
        .en_i     (span_en),
        .sample_i (demod[gi]),
        .max_o    (ch_max[gi]),
        .min_o    (ch_min[gi]),
        .span_o   (ch_span[gi])
      );
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Control conditions
  // -------------------------------------------------------------------------
  logic hold_done;
  logic win_last;

  assign hold_done = (hold_cnt_q == HOLD_LAST);
  assign win_last  = (win_cnt_q == WIN_LAST);
  assign span_en   = (state_q == ST_SPAN) && sample_en;

  // Single definition of "enter SPAN": start and HOLD expiry arriving
  // together still give one entry, and start is ignored while busy.
  always_comb begin
    start_span = 1'b0;
    if (state_q == ST_IDLE) begin
      start_span = start || auto_en;
    end else if (state_q == ST_HOLD) begin
      start_span = start || (hold_done && auto_en);
    end
  end

  // -------------------------------------------------------------------------
  // Channel activity and SHAPE setup (evaluated from the held spans)
  // -------------------------------------------------------------------------
  logic am_act;
  logic fm_act;
  logic pm_act;

  assign am_act = (ch_span[0] > AM_TH_V);
  assign fm_act = (ch_span[1] > FM_TH_V);
  assign pm_act = (ch_span[2] > PM_TH_V);

  chan_sel_t                  sel_d;
  logic [1:0]                 ref_idx;
  logic signed [SPAN_W-1:0]   mid_sum;
  logic signed [SPAN_W-1:0]   mid_half;
  logic signed [IO_width-1:0] center_d;
  logic [SPAN_W-1:0]          band_d;

  always_comb begin
    sel_d   = CH_NONE;
    ref_idx = 2'd2;
    if (am_act) begin
      sel_d   = CH_AM;
      ref_idx = 2'd0;
    end else if (fm_act) begin
      sel_d   = CH_FM;
      ref_idx = 2'd1;
    end
  end

  // Arithmetic shift of the widened sum gives floor((max+min)/2), which
  // always lies between min and max and therefore fits IO_width bits.
  assign mid_sum  = {ch_max[ref_idx][IO_width-1], ch_max[ref_idx]}
                  + {ch_min[ref_idx][IO_width-1], ch_min[ref_idx]};
  assign mid_half = mid_sum >>> 1;
  assign center_d = mid_half[IO_width-1:0];
  assign band_d   = ch_span[ref_idx] >> 2;

  // -------------------------------------------------------------------------
  // Mid-band detector on the selected channel during the SHAPE window
  // -------------------------------------------------------------------------
  logic signed [IO_width-1:0] shape_x;
  logic signed [SPAN_W-1:0]   x_dev;
  logic [SPAN_W-1:0]          x_abs;
  logic                       in_band;

  assign shape_x = (sel_q == CH_FM) ? FM_demod : AM_demod;
  assign x_dev   = {shape_x[IO_width-1], shape_x} - {center_q[IO_width-1], center_q};
  // |x_dev| < 2^IO_width, so negation in SPAN_W bits never overflows.
  assign x_abs   = x_dev[SPAN_W-1] ? -x_dev : x_dev;
  assign in_band = (x_abs < band_q);

  // -------------------------------------------------------------------------
  // Decision: keyed shapes rarely sit near the mid level.
  // -------------------------------------------------------------------------
  logic       keyed;
  logic [2:0] type_d;

  assign keyed = (mid_cnt_q < MID_LIM);

  always_comb begin
    type_d = pm_act ? TYPE_PSK : TYPE_CW;
    if (sel_q == CH_AM) begin
      type_d = keyed ? TYPE_ASK : TYPE_AM;
    end else if (sel_q == CH_FM) begin
      type_d = keyed ? TYPE_FSK : TYPE_FM;
    end
  end

  // -------------------------------------------------------------------------
  // FSM with registered trigger/type/busy outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sel_q         <= CH_NONE;
      win_cnt_q     <= '0;
      mid_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      shape_armed_q <= 1'b0;
      center_q      <= '0;
      band_q        <= '0;
      signal_type_q <= TYPE_NA;
      meas_q        <= 1'b0;
      cal_q         <= 1'b0;
      out_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      meas_q <= 1'b0;
      cal_q  <= 1'b0;
      out_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start_span) begin
            state_q   <= ST_SPAN;
            meas_q    <= 1'b1;
            busy_q    <= 1'b1;
            win_cnt_q <= '0;
          end
        end

        ST_SPAN: begin
          if (sample_en) begin
            if (win_last) begin
              state_q       <= ST_SHAPE;
              cal_q         <= 1'b1;
              win_cnt_q     <= '0;
              shape_armed_q <= 1'b0;
            end else begin
              win_cnt_q <= win_cnt_q + WIN_W'(1);
            end
          end
        end

        ST_SHAPE: begin
          if (!shape_armed_q) begin
            sel_q     <= sel_d;
            center_q  <= center_d;
            band_q    <= band_d;
            mid_cnt_q <= '0;
            win_cnt_q <= '0;
            if (sel_d == CH_NONE) begin
              state_q <= ST_DECIDE;
            end else begin
              shape_armed_q <= 1'b1;
            end
          end else if (sample_en) begin
            mid_cnt_q <= mid_cnt_q + (WIN_W + 1)'(in_band);
            if (win_last) begin
              state_q       <= ST_DECIDE;
              shape_armed_q <= 1'b0;
              win_cnt_q     <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + WIN_W'(1);
            end
          end
        end

        ST_DECIDE: begin
          signal_type_q <= type_d;
          out_q         <= 1'b1;
          busy_q        <= 1'b0;
          hold_cnt_q    <= '0;
          state_q       <= ST_HOLD;
        end

        ST_HOLD: begin
          if (start_span) begin
            state_q    <= ST_SPAN;
            meas_q     <= 1'b1;
            busy_q     <= 1'b1;
            win_cnt_q  <= '0;
            hold_cnt_q <= '0;
          end else if (hold_done) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign meas_trigger = meas_q;
  assign cal_trigger  = cal_q;
  assign out_trigger  = out_q;
  assign signal_type  = signal_type_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mod_type_classifier.sv
// ---------------------------------------------------------------------------
// tb_mod_type_classifier
//   Each channel replays a 16-entry periodic table, one entry per enabled
//   sample. Any 64 consecutive samples hold every table entry exactly four
//   times, so the expected class follows from the table alone.
// ---------------------------------------------------------------------------
module tb_mod_type_classifier;

  localparam int IOW  = 14;
  localparam int WIN  = 64;
  localparam int HOLD = 200;
  localparam int TH   = 800;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  sample_en = 1'b0;
  logic                  start = 1'b0;
  logic                  auto_en = 1'b0;
  logic signed [IOW-1:0] AM_demod = '0;
  logic signed [IOW-1:0] FM_demod = '0;
  logic signed [IOW-1:0] PM_demod = '0;
  logic                  meas_trigger;
  logic                  cal_trigger;
  logic                  out_trigger;
  logic [2:0]            signal_type;
  logic                  busy;

  mod_type_classifier #(
    .IO_width  (IOW),
    .WIN_LEN   (WIN),
    .HOLD_LEN  (HOLD),
    .AM_TH     (TH),
    .FM_TH     (TH),
    .PM_TH     (TH),
    .MID_SHIFT (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .start        (start),
    .auto_en      (auto_en),
    .AM_demod     (AM_demod),
    .FM_demod     (FM_demod),
    .PM_demod     (PM_demod),
    .meas_trigger (meas_trigger),
    .cal_trigger  (cal_trigger),
    .out_trigger  (out_trigger),
    .signal_type  (signal_type),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  int tbl [3][16];
  int sin16 [16] = '{0, 3827, 7071, 9239, 10000, 9239, 7071, 3827,
                     0, -3827, -7071, -9239, -10000, -9239, -7071, -3827};
  int phase = 0;
  int cyc = 0;

  int meas_cnt = 0, cal_cnt = 0, out_cnt = 0;
  int meas_cyc = 0, cal_cyc = 0, out_cyc = 0;
  int meas_samp = 0, cal_samp = 0, samp_cnt = 0;
  int type_glitch = 0;
  logic [2:0] prev_type = 3'b100;

  // Sample source: strobe every 4th clock, advance the table after each
  // strobe the DUT has consumed.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sample_en) phase = (phase + 1) % 16;
      cyc++;
      sample_en = (cyc % 4 == 0);
      AM_demod  = 14'(tbl[0][phase]);
      FM_demod  = 14'(tbl[1][phase]);
      PM_demod  = 14'(tbl[2][phase]);
    end
  end

  // Trigger monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (meas_trigger) begin meas_cnt++; meas_cyc = cyc; meas_samp = samp_cnt; end
      if (cal_trigger)  begin cal_cnt++;  cal_cyc  = cyc; cal_samp  = samp_cnt; end
      if (out_trigger)  begin out_cnt++;  out_cyc  = cyc; end
      if ((signal_type !== prev_type) && !out_trigger) type_glitch++;
      prev_type = signal_type;
    end else begin
      prev_type = 3'b100;
    end
    if (sample_en) samp_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // kind: 0 zero, 1 sine, 2 square, 3 random uniform, 4 random keyed,
  //       5 square from +amp+1 to -amp
  task automatic fill_chan(input int ch, input int kind, input int amp);
    for (int p = 0; p < 16; p++) begin
      case (kind)
        1:       tbl[ch][p] = amp * sin16[p] / 10000;
        2:       tbl[ch][p] = (p < 8) ? amp : -amp;
        3:       tbl[ch][p] = int'($urandom_range(0, 2 * amp)) - amp;
        4:       tbl[ch][p] = ($urandom_range(0, 1) == 1) ? amp : -amp;
        5:       tbl[ch][p] = (p < 8) ? amp + 1 : -amp;
        default: tbl[ch][p] = 0;
      endcase
    end
  endtask

  task automatic set_tables(input int ka, input int aa, input int kf, input int af,
                            input int kp, input int ap);
    fill_chan(0, ka, aa);
    fill_chan(1, kf, af);
    fill_chan(2, kp, ap);
  endtask

  // Classification straight from the rules: spans, strict thresholds,
  // mid-band count over four table periods.
  function automatic logic [2:0] model_type();
    int mx [3];
    int mn [3];
    int sp [3];
    int ch, ctr, band, hits, d;
    for (int c = 0; c < 3; c++) begin
      mx[c] = tbl[c][0];
      mn[c] = tbl[c][0];
      for (int p = 1; p < 16; p++) begin
        if (tbl[c][p] > mx[c]) mx[c] = tbl[c][p];
        if (tbl[c][p] < mn[c]) mn[c] = tbl[c][p];
      end
      sp[c] = mx[c] - mn[c];
    end
    ch = (sp[0] > TH) ? 0 : (sp[1] > TH) ? 1 : -1;
    if (ch >= 0) begin
      ctr  = (mx[ch] + mn[ch]) >>> 1;
      band = sp[ch] >> 2;
      hits = 0;
      for (int p = 0; p < 16; p++) begin
        d = tbl[ch][p] - ctr;
        if (d < 0) d = -d;
        if (d < band) hits += WIN / 16;
      end
      if (ch == 0) return (hits < (WIN >> 3)) ? 3'b101 : 3'b001;
      return (hits < (WIN >> 3)) ? 3'b110 : 3'b010;
    end
    return (sp[2] > TH) ? 3'b111 : 3'b000;
  endfunction

  task automatic wait_evt(input int which, input int base, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(posedge clk);
      #2;
      case (which)
        0:       ok = (meas_cnt != base);
        1:       ok = (cal_cnt != base);
        default: ok = (out_cnt != base);
      endcase
    end
  endtask

  task automatic run_case(input string tag, input logic [2:0] exp_type, input bit extra_start);
    int  m0, c0, o0;
    bit  ok;
    m0 = meas_cnt; c0 = cal_cnt; o0 = out_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (extra_start) begin
      repeat (60) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_evt(2, o0, 3000, ok);
    check({tag, "_done"}, ok, 1);
    check({tag, "_meas1"}, meas_cnt - m0, 1);
    check({tag, "_cal1"}, cal_cnt - c0, 1);
    check({tag, "_order"}, (meas_cyc < cal_cyc) && (cal_cyc < out_cyc), 1);
    check({tag, "_win"}, cal_samp - meas_samp, WIN);
    check({tag, "_type"}, signal_type, exp_type);
    check({tag, "_busy_hold"}, busy, 0);
    $display("case %s: signal_type=%03b expected=%03b", tag, signal_type, exp_type);
    repeat (HOLD + 20) @(posedge clk);
    #2;
    check({tag, "_out1"}, out_cnt - o0, 1);
    check({tag, "_no_restart"}, meas_cnt - m0, 1);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    bit ok;
    int m0, o0, cls, amp;
    logic [2:0] exp_t;

    for (int c = 0; c < 3; c++) fill_chan(c, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_type", signal_type, 3'b100);
    check("rst_trig", {meas_trigger, cal_trigger, out_trigger}, 3'b000);
    check("rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("idle_type", signal_type, 3'b100);
    check("idle_meas", meas_cnt, 0);

    // Directed classes
    set_tables(0, 0, 0, 0, 0, 0);       run_case("cw",        3'b000, 1'b0);
    set_tables(1, 3000, 0, 0, 0, 0);    run_case("am_sine",   3'b001, 1'b0);
    set_tables(2, 3000, 0, 0, 0, 0);    run_case("ask",       3'b101, 1'b0);
    set_tables(0, 0, 2, 2000, 0, 0);    run_case("fsk",       3'b110, 1'b0);
    set_tables(0, 0, 1, 2000, 0, 0);    run_case("fm_sine",   3'b010, 1'b0);
    set_tables(0, 0, 0, 0, 2, 1500);    run_case("psk",       3'b111, 1'b0);
    set_tables(2, 400, 2, 400, 2, 400); run_case("th_equal",  3'b000, 1'b0);
    set_tables(5, 400, 0, 0, 0, 0);     run_case("th_plus1",  3'b101, 1'b0);
    set_tables(1, 3000, 0, 0, 0, 0);    run_case("busy_start", 3'b001, 1'b1);

    // Randomized tables against the model
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 3; c++) begin
        cls = $urandom_range(0, 2);
        amp = (cls == 0) ? 0 : (cls == 1) ? int'($urandom_range(1, 399))
                                           : int'($urandom_range(500, 4000));
        fill_chan(c, int'($urandom_range(3, 4)), amp);
      end
      exp_t = model_type();
      run_case($sformatf("rand%0d", r), exp_t, 1'b0);
    end

    // Automatic re-measure: next meas_trigger HOLD clocks after out_trigger
    set_tables(0, 0, 2, 2000, 0, 0);
    o0 = out_cnt;
    @(posedge clk); #1 auto_en = 1'b1;
    wait_evt(2, o0, 3000, ok);
    check("auto_out", ok, 1);
    check("auto_type", signal_type, 3'b110);
    m0 = meas_cnt;
    wait_evt(0, m0, HOLD + 50, ok);
    check("auto_meas", ok, 1);
    check("auto_delay", meas_cyc - out_cyc, HOLD);
    $display("auto: meas_trigger %0d clk after out_trigger", meas_cyc - out_cyc);
    auto_en = 1'b0;
    o0 = out_cnt;
    wait_evt(2, o0, 3000, ok);
    check("auto_out2", ok, 1);
    repeat (HOLD + 20) @(posedge clk);
    #2;
    check("auto_idle", busy, 0);

    // Reset during SHAPE
    set_tables(1, 3000, 0, 0, 0, 0);
    m0 = cal_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_evt(1, m0, 1000, ok);
    check("rst_reach_shape", ok, 1);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_type", signal_type, 3'b100);
    check("async_rst_trig", {meas_trigger, cal_trigger, out_trigger}, 3'b000);
    check("async_rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    o0 = out_cnt; m0 = meas_cnt;
    repeat (1000) @(posedge clk);
    #2;
    check("post_rst_no_out", out_cnt - o0, 0);
    check("post_rst_no_meas", meas_cnt - m0, 0);
    check("post_rst_type", signal_type, 3'b100);
    $display("reset in SHAPE: signal_type=%03b", signal_type);

    set_tables(2, 3000, 0, 0, 0, 0);    run_case("recover",   3'b101, 1'b0);

    check("type_only_on_out", type_glitch, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
